// File: rtl/sram_emu.sv
// sram_emu: synchronous stand-in for a 512Kx16 asynchronous SRAM part.
// It answers the same pin protocol the SRAM controller drives, and it stores
// its data in an inferred block RAM of 2^DEPTH_W words.
//
// Parameters:
//   DEPTH_W     internal address width. Pin addresses alias modulo 2^DEPTH_W.
//   MIN_WE_CYC  minimum sampled we_n low width, in cycles, for a write to commit.
//
// Ports:
//   clk, rst          clock, and a synchronous active-high reset
//   sram_ce_n         chip enable (active-low)
//   sram_we_n         write enable (active-low)
//   sram_oe_n         output enable (active-low)
//   sram_lb_n         lower byte lane enable (active-low)
//   sram_ub_n         upper byte lane enable (active-low)
//   sram_addr         word address
//   sram_data_in      write data from the controller
//   sram_data_out     registered read data
//   sram_data_oe      drive enable for sram_data_out
//   err_contention    sticky flag: we_n and oe_n were sampled low together
//   err_short_we      sticky flag: a write pulse was shorter than MIN_WE_CYC
//
// Build option: define SRAM_EMU_BYTE_LANE_EN to honour lb_n/ub_n.
// When it is undefined, every access is a full 16-bit word.
//
// FSM states:
//   state   | meaning
//   IDLE    | no access in progress
//   WR      | write pulse active; address, data and lanes are latched every cycle
//   RD      | read active; data_out follows memory with a two-cycle lag
module sram_emu #(
  parameter int DEPTH_W    = 12,
  parameter int MIN_WE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_ce_n,
  input  logic        sram_we_n,
  input  logic        sram_oe_n,
  input  logic        sram_lb_n,
  input  logic        sram_ub_n,
  input  logic [18:0] sram_addr,
  input  logic [15:0] sram_data_in,
  output logic [15:0] sram_data_out,
  output logic        sram_data_oe,
  output logic        err_contention,
  output logic        err_short_we
);

  localparam int CNT_W = (MIN_WE_CYC < 1) ? 1 : $clog2(MIN_WE_CYC + 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WE_CYC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  // sampled pins
  logic               ce_n_s, we_n_s, oe_n_s, lb_n_s, ub_n_s;
  logic [DEPTH_W-1:0] addr_s;
  logic [15:0]        data_s;

  logic [1:0]         state, state_nx;
  logic [CNT_W-1:0]   we_cnt;
  logic [DEPTH_W-1:0] wr_addr;
  logic [15:0]        wr_data;
  logic               wr_lb_n, wr_ub_n;

  logic               wr_req, rd_req, contention, wr_exit, commit, short_we;
  logic               we_lo, we_hi;
  logic [15:0]        mem [0:(2**DEPTH_W)-1];
  logic [15:0]        rd_word, rd_next, rd_q;

  // Upper address bits are deliberately ignored (aliasing).
  if (DEPTH_W < 19) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^sram_addr[18:DEPTH_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_n_s <= 1'b1;
      we_n_s <= 1'b1;
      oe_n_s <= 1'b1;
      lb_n_s <= 1'b1;
      ub_n_s <= 1'b1;
      addr_s <= '0;
      data_s <= '0;
    end else begin
      ce_n_s <= sram_ce_n;
      we_n_s <= sram_we_n;
      oe_n_s <= sram_oe_n;
      lb_n_s <= sram_lb_n;
      ub_n_s <= sram_ub_n;
      addr_s <= sram_addr[DEPTH_W-1:0];
      data_s <= sram_data_in;
    end
  end

  assign wr_req     = !ce_n_s && !we_n_s;
  assign rd_req     = !ce_n_s && !oe_n_s;
  assign contention = !we_n_s && !oe_n_s;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (wr_req)      state_nx = ST_WR;
        else if (rd_req) state_nx = ST_RD;
      end
      ST_WR: begin
        if (we_n_s || ce_n_s) state_nx = ST_IDLE;
      end
      ST_RD: begin
        // A write request takes priority over a continuing read.
        if (wr_req)                state_nx = ST_WR;
        else if (oe_n_s || ce_n_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // The pulse is judged on the cycle it ends, using its width at that point.
  assign wr_exit  = (state == ST_WR) && (we_n_s || ce_n_s);
  assign commit   = wr_exit && (we_cnt >= MIN_CNT);
  assign short_we = wr_exit && (we_cnt < MIN_CNT);

`ifdef SRAM_EMU_BYTE_LANE_EN
  assign we_lo = commit && !wr_lb_n;
  assign we_hi = commit && !wr_ub_n;
`else
  assign we_lo = commit;
  assign we_hi = commit;
  logic unused_lanes;
  assign unused_lanes = wr_lb_n ^ wr_ub_n ^ lb_n_s ^ ub_n_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_cnt  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_lb_n <= 1'b1;
      wr_ub_n <= 1'b1;
    end else begin
      state <= state_nx;
      if (state_nx == ST_WR) begin
        wr_addr <= addr_s;
        wr_data <= data_s;
        wr_lb_n <= lb_n_s;
        wr_ub_n <= ub_n_s;
        if (state != ST_WR)   we_cnt <= CNT_W'(1);
        else if (we_cnt != '1) we_cnt <= we_cnt + CNT_W'(1);
      end else begin
        we_cnt <= '0;
      end
    end
  end

  // Memory is not reset. It has a single read port and byte-wide write strobes.
  always_ff @(posedge clk) begin
    if (we_lo) mem[wr_addr][7:0]  <= wr_data[7:0];
    if (we_hi) mem[wr_addr][15:8] <= wr_data[15:8];
  end

  assign rd_word = mem[addr_s];

  // Write-first: a lane that is committed this cycle to the address being
  // read returns the new byte.
  always_comb begin
    rd_next[7:0]  = (we_lo && (wr_addr == addr_s)) ? wr_data[7:0]  : rd_word[7:0];
    rd_next[15:8] = (we_hi && (wr_addr == addr_s)) ? wr_data[15:8] : rd_word[15:8];
`ifdef SRAM_EMU_BYTE_LANE_EN
    if (lb_n_s) rd_next[7:0]  = 8'h00;
    if (ub_n_s) rd_next[15:8] = 8'h00;
`endif
  end

  // Two stages, sampled address -> rd_q -> data_out, give the two-cycle read
  // latency. data_oe is derived from the registered state so that it also
  // trails oe_n by two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q           <= '0;
      sram_data_out  <= '0;
      sram_data_oe   <= 1'b0;
      err_contention <= 1'b0;
      err_short_we   <= 1'b0;
    end else begin
      rd_q <= rd_next;
      if (state == ST_RD) sram_data_out <= rd_q;
      sram_data_oe   <= (state == ST_RD) && !ce_n_s && !contention;
      err_contention <= err_contention || contention;
      err_short_we   <= err_short_we || short_we;
    end
  end

endmodule

// File: tb/tb_sram_emu.sv
module tb_sram_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_ce_n = 1'b1;
  logic        sram_we_n = 1'b1;
  logic        sram_oe_n = 1'b1;
  logic        sram_lb_n = 1'b0;
  logic        sram_ub_n = 1'b0;
  logic [18:0] sram_addr = '0;
  logic [15:0] sram_data_in = '0;
  logic [15:0] sram_data_out;
  logic        sram_data_oe;
  logic        err_contention;
  logic        err_short_we;

  always #5 clk = ~clk;

  sram_emu #(.DEPTH_W(12), .MIN_WE_CYC(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .sram_ce_n      (sram_ce_n),
    .sram_we_n      (sram_we_n),
    .sram_oe_n      (sram_oe_n),
    .sram_lb_n      (sram_lb_n),
    .sram_ub_n      (sram_ub_n),
    .sram_addr      (sram_addr),
    .sram_data_in   (sram_data_in),
    .sram_data_out  (sram_data_out),
    .sram_data_oe   (sram_data_oe),
    .err_contention (err_contention),
    .err_short_we   (err_short_we)
  );

`ifdef SRAM_EMU_BYTE_LANE_EN
  localparam bit LANES = 1'b1;
`else
  localparam bit LANES = 1'b0;
`endif

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_read(input logic [18:0] a, input logic lb, input logic ub);
    logic [15:0] w;
    w = ref_mem[a[11:0]];
    if (LANES && lb) w[7:0]  = 8'h00;
    if (LANES && ub) w[15:8] = 8'h00;
    return w;
  endfunction

  // A write pulse of w cycles. oe_low also holds oe_n low, which produces contention.
  task automatic do_write(input logic [18:0] a, input logic [15:0] d, input int w,
                          input logic lb, input logic ub, input logic oe_low);
    sram_ce_n = 1'b0; sram_we_n = 1'b0; sram_oe_n = !oe_low;
    sram_addr = a; sram_data_in = d; sram_lb_n = lb; sram_ub_n = ub;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      if (oe_low) chk("contention_oe", sram_data_oe, 0);
    end
    sram_we_n = 1'b1; sram_oe_n = 1'b1; sram_ce_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (oe_low) chk("contention_oe", sram_data_oe, 0);
    end
    if (w >= 2) begin
      if (!LANES || !lb) ref_mem[a[11:0]][7:0]  = d[7:0];
      if (!LANES || !ub) ref_mem[a[11:0]][15:8] = d[15:8];
    end
  endtask

  // Continuous read: one address per cycle. Expected words go to the scoreboard.
  task automatic read_burst(input logic [18:0] addrs[$], input logic lb, input logic ub);
    int len;
    len = addrs.size();
    for (int i = 0; i < len + 3; i++) begin
      if (i < len) begin
        sram_ce_n = 1'b0; sram_oe_n = 1'b0; sram_we_n = 1'b1;
        sram_addr = addrs[i]; sram_lb_n = lb; sram_ub_n = ub;
        exp_q.push_back(model_read(addrs[i], lb, ub));
      end else if (i == len) begin
        sram_oe_n = 1'b1;
      end else if (i == len + 1) begin
        sram_ce_n = 1'b1;
      end
      @(negedge clk);
      if (i == 1)       chk("oe_not_yet", sram_data_oe, 0);
      if (i == 2)       chk("oe_rise", sram_data_oe, 1);
      if (i == len + 1) chk("oe_hold", sram_data_oe, 1);
      if (i == len + 2) chk("oe_release", sram_data_oe, 0);
    end
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (sram_data_oe === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rd_unexpected: actual=%h required=no output t=%0t", sram_data_out, $time);
        end else begin
          chk("rd_data", sram_data_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] aq[$];
    logic [18:0] a;
    int          n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data_out", sram_data_out, 0);
    chk("rst_data_oe", sram_data_oe, 0);
    chk("rst_err_cont", err_contention, 0);
    chk("rst_err_short", err_short_we, 0);

    for (int i = 0; i < 32; i++)
      do_write(19'(i), 16'($urandom), 2, 1'b0, 1'b0, 1'b0);
    chk("init_err_short", err_short_we, 0);
    chk("init_err_cont", err_contention, 0);

    do_write(19'h00010, 16'hA5C3, 2, 1'b0, 1'b0, 1'b0);
    aq.delete(); aq.push_back(19'h00010);
    read_burst(aq, 1'b0, 1'b0);

    do_write(19'h00005, 16'h1234, 1, 1'b0, 1'b0, 1'b0);
    chk("short_flag", err_short_we, 1);
    aq.delete(); aq.push_back(19'h00005);
    read_burst(aq, 1'b0, 1'b0);

    do_write(19'h00007, 16'hBEEF, 3, 1'b0, 1'b0, 1'b1);
    chk("cont_flag", err_contention, 1);
    aq.delete(); aq.push_back(19'h00007);
    read_burst(aq, 1'b0, 1'b0);

    do_write(19'h01000, 16'h0F0F, 2, 1'b0, 1'b0, 1'b0);
    aq.delete(); aq.push_back(19'h00000);
    read_burst(aq, 1'b0, 1'b0);

    aq.delete();
    for (int i = 0; i < 4; i++) begin
      do_write(19'(i), 16'(i), 2, 1'b0, 1'b0, 1'b0);
      aq.push_back(19'(i));
    end
    read_burst(aq, 1'b0, 1'b0);

    do_write(19'h00009, 16'hFFFF, 2, 1'b0, 1'b0, 1'b0);
    do_write(19'h00009, 16'h1200, 2, 1'b1, 1'b0, 1'b0);
    aq.delete(); aq.push_back(19'h00009);
    read_burst(aq, 1'b0, 1'b0);

    for (int k = 0; k < 50; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = {7'($urandom), 12'($urandom_range(0, 31))};
        do_write(a, 16'($urandom), int'($urandom_range(1, 4)),
                 1'($urandom), 1'($urandom), 1'b0);
      end else begin
        aq.delete();
        n = int'($urandom_range(1, 4));
        for (int j = 0; j < n; j++)
          aq.push_back({7'($urandom), 12'($urandom_range(0, 31))});
        read_burst(aq, 1'($urandom), 1'($urandom));
      end
    end
    chk("short_sticky", err_short_we, 1);
    chk("cont_sticky", err_contention, 1);

    // reset lands while the write to addr 3 is in its WR state
    sram_ce_n = 1'b0; sram_we_n = 1'b0; sram_oe_n = 1'b1;
    sram_addr = 19'h00003; sram_data_in = 16'h5555; sram_lb_n = 1'b0; sram_ub_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sram_we_n = 1'b1; sram_ce_n = 1'b1;
    @(negedge clk);
    chk("mrst_data_out", sram_data_out, 0);
    chk("mrst_data_oe", sram_data_oe, 0);
    chk("mrst_err_cont", err_contention, 0);
    chk("mrst_err_short", err_short_we, 0);
    repeat (3) @(negedge clk);
    aq.delete(); aq.push_back(19'h00003);
    read_burst(aq, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
